// File: rtl/cop_req_ctrl.sv
// Coprocessor request controller: issues custom-opcode instructions,
// buffers results in a 2-entry FIFO and arbitrates them to writeback.
module cop_req_ctrl #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        cop_clk,
   input  logic        cop_rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_insn,
   input  logic [31:0] ex_rs1,
   input  logic [31:0] ex_rs2,
   input  logic [4:0]  ex_rd_addr,
   output logic        ex_ready,
   output logic        ex_illegal,
   output logic        ex_fault,
   output logic        cop_busy,
   output logic        cop_valid,
   output logic [31:0] cop_insn,
   output logic [31:0] cop_rs1,
   output logic [31:0] cop_rs2,
   output logic        cop_rdywr,
   input  logic        cop_ready,
   input  logic        cop_wait,
   input  logic        cop_wr,
   input  logic [31:0] cop_rd,
   output logic        wb_req,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   input  logic        wb_gnt
);

   localparam logic [7:0] WMAX = 8'(WAIT_MAX);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t      state;
   logic [4:0]  rd_q;
   logic [7:0]  wait_cnt;
   logic [36:0] fifo_mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic custom;
   logic done;
   logic accept;
   logic push;
   logic pop;
   logic abort;

   assign custom = (ex_insn[6:0] == 7'b0001011)
                 | (ex_insn[6:0] == 7'b0101011)
                 | (ex_insn[6:0] == 7'b1011011)
                 | (ex_insn[6:0] == 7'b1111011);

   assign done     = (state == ISSUE) & cop_ready & ~cop_wait;
   assign ex_ready = (state == IDLE) | done;
   assign accept   = ex_valid & custom & ex_ready;
   assign push     = done & cop_wr & (rd_q != 5'd0);
   assign abort    = (state == ISSUE) & cop_wait
                   & ((wait_cnt + 8'd1) == WMAX);

   assign cop_valid = (state == ISSUE);
   assign wb_req    = (count != 2'd0);
   assign pop       = wb_req & wb_gnt;
   assign cop_rdywr = ~count[1];
   assign cop_busy  = cop_valid | wb_req;
   assign wb_addr   = fifo_mem[rd_ptr][36:32];
   assign wb_data   = fifo_mem[rd_ptr][31:0];

   always_ff @(posedge cop_clk) begin
      if (cop_rst) begin
         state      <= IDLE;
         rd_q       <= '0;
         wait_cnt   <= '0;
         cop_insn   <= '0;
         cop_rs1    <= '0;
         cop_rs2    <= '0;
         ex_illegal <= 1'b0;
         ex_fault   <= 1'b0;
      end else begin
         ex_illegal <= done & ~cop_wr;
         ex_fault   <= abort;
         if (accept) begin
            state    <= ISSUE;
            rd_q     <= ex_rd_addr;
            wait_cnt <= '0;
            cop_insn <= ex_insn;
            cop_rs1  <= ex_rs1;
            cop_rs2  <= ex_rs2;
         end else if (done || abort) begin
            state <= IDLE;
         end else if (state == ISSUE && cop_wait) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge cop_clk) begin
      if (cop_rst) begin
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= '0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= {rd_q, cop_rd};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // The coprocessor must hold off while cop_rdywr is low.
   assert property (@(posedge cop_clk) disable iff (cop_rst)
      !(push && count == 2'd2));

endmodule

// File: tb/tb_cop_req_ctrl.sv
// Directed bench for cop_req_ctrl with a reference model
// and a writeback scoreboard queue.
module tb_cop_req_ctrl;

   logic        cop_clk = 1'b0;
   logic        cop_rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic [31:0] ex_insn = '0;
   logic [31:0] ex_rs1 = '0;
   logic [31:0] ex_rs2 = '0;
   logic [4:0]  ex_rd_addr = '0;
   logic        ex_ready;
   logic        ex_illegal;
   logic        ex_fault;
   logic        cop_busy;
   logic        cop_valid;
   logic [31:0] cop_insn;
   logic [31:0] cop_rs1;
   logic [31:0] cop_rs2;
   logic        cop_rdywr;
   logic        cop_ready = 1'b0;
   logic        cop_wait = 1'b0;
   logic        cop_wr = 1'b0;
   logic [31:0] cop_rd = '0;
   logic        wb_req;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_gnt = 1'b0;

   always #5 cop_clk = ~cop_clk;

   cop_req_ctrl #(.WAIT_MAX(4)) dut (
      .cop_clk    (cop_clk),
      .cop_rst    (cop_rst),
      .ex_valid   (ex_valid),
      .ex_insn    (ex_insn),
      .ex_rs1     (ex_rs1),
      .ex_rs2     (ex_rs2),
      .ex_rd_addr (ex_rd_addr),
      .ex_ready   (ex_ready),
      .ex_illegal (ex_illegal),
      .ex_fault   (ex_fault),
      .cop_busy   (cop_busy),
      .cop_valid  (cop_valid),
      .cop_insn   (cop_insn),
      .cop_rs1    (cop_rs1),
      .cop_rs2    (cop_rs2),
      .cop_rdywr  (cop_rdywr),
      .cop_ready  (cop_ready),
      .cop_wait   (cop_wait),
      .cop_wr     (cop_wr),
      .cop_rd     (cop_rd),
      .wb_req     (wb_req),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .wb_gnt     (wb_gnt)
   );

   localparam logic [31:0] C0 = 32'h0010_000B;
   localparam logic [31:0] C1 = 32'h0020_002B;
   localparam logic [31:0] C2 = 32'h0030_005B;
   localparam logic [31:0] C3 = 32'h0040_007B;
   localparam logic [31:0] ALU = 32'h0050_0033;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int wb_seen = 0;

   logic [36:0] q [$];

   logic        m_issue, m_ill, m_flt;
   logic [4:0]  m_rd;
   int          m_cnt;
   logic [31:0] m_insn, m_rs1, m_rs2;

   logic        n_issue, n_ill, n_flt, n_push, n_pop;
   logic [4:0]  n_rd;
   int          n_cnt;
   logic [31:0] n_insn, n_rs1, n_rs2;
   logic [36:0] n_ent;

   task automatic chk(string tag, logic [63:0] obs,
                      logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic drive(logic ev, logic [31:0] insn,
                        logic [31:0] rs1, logic [4:0] rd,
                        logic rdy, logic wt, logic wr,
                        logic [31:0] rdat, logic gnt);
      bit cust;
      bit done_m;
      bit acc;
      ex_valid = ev;
      ex_insn = insn;
      ex_rs1 = rs1;
      ex_rs2 = ~rs1;
      ex_rd_addr = rd;
      cop_ready = rdy;
      cop_wait = wt;
      cop_wr = wr;
      cop_rd = rdat;
      wb_gnt = gnt;
      #1;
      cust = insn[6:0] inside {7'h0B, 7'h2B, 7'h5B, 7'h7B};
      done_m = m_issue && rdy && !wt;
      acc = ev && cust && (!m_issue || done_m);
      chk("ex_ready", ex_ready, !m_issue || done_m);
      chk("cop_rdywr", cop_rdywr, q.size() < 2);
      n_pop = (q.size() != 0) && gnt;
      if (n_pop) begin
         wb_seen++;
         chk("wb_addr_pop", wb_addr, q[0][36:32]);
         chk("wb_data_pop", wb_data, q[0][31:0]);
      end
      n_push = done_m && wr && (m_rd != 5'd0);
      n_ent = {m_rd, rdat};
      n_ill = done_m && !wr;
      n_flt = 1'b0;
      n_issue = m_issue;
      n_cnt = m_cnt;
      n_rd = m_rd;
      n_insn = m_insn;
      n_rs1 = m_rs1;
      n_rs2 = m_rs2;
      if (acc) begin
         n_issue = 1'b1;
         n_cnt = 0;
         n_rd = rd;
         n_insn = insn;
         n_rs1 = rs1;
         n_rs2 = ~rs1;
      end else if (done_m) begin
         n_issue = 1'b0;
      end else if (m_issue && wt) begin
         if (m_cnt + 1 == 4) begin
            n_flt = 1'b1;
            n_issue = 1'b0;
         end else begin
            n_cnt = m_cnt + 1;
         end
      end
   endtask

   task automatic clk_edge();
      @(posedge cop_clk);
      #1;
      if (cop_rst) begin
         q.delete();
         m_issue = 1'b0;
         m_ill = 1'b0;
         m_flt = 1'b0;
         m_rd = '0;
         m_cnt = 0;
         m_insn = '0;
         m_rs1 = '0;
         m_rs2 = '0;
      end else begin
         if (n_pop) void'(q.pop_front());
         if (n_push) q.push_back(n_ent);
         m_issue = n_issue;
         m_ill = n_ill;
         m_flt = n_flt;
         m_rd = n_rd;
         m_cnt = n_cnt;
         m_insn = n_insn;
         m_rs1 = n_rs1;
         m_rs2 = n_rs2;
      end
      chk("cop_valid", cop_valid, m_issue);
      chk("wb_req", wb_req, q.size() != 0);
      chk("ex_illegal", ex_illegal, m_ill);
      chk("ex_fault", ex_fault, m_flt);
      chk("cop_busy", cop_busy, m_issue || q.size() != 0);
      chk("cop_insn", cop_insn, m_insn);
      chk("cop_rs1", cop_rs1, m_rs1);
      chk("cop_rs2", cop_rs2, m_rs2);
      if (q.size() != 0) begin
         chk("wb_addr_head", wb_addr, q[0][36:32]);
         chk("wb_data_head", wb_data, q[0][31:0]);
      end
   endtask

   task automatic idle(logic gnt);
      drive(0, '0, '0, '0, 0, 0, 0, '0, gnt);
   endtask

   task automatic reset_vals();
      chk("rst_wb_addr", wb_addr, 5'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_ex_ready", ex_ready, 1'b1);
      chk("rst_cop_rdywr", cop_rdywr, 1'b1);
      chk("rst_cop_valid", cop_valid, 1'b0);
      chk("rst_cop_busy", cop_busy, 1'b0);
   endtask

   initial begin
      // reset
      cop_rst = 1'b1;
      clk_edge();
      clk_edge();
      reset_vals();
      cop_rst = 1'b0;

      // single op, custom-2, rd=5
      drive(1, C2, 32'h1234_5678, 5'd5, 0, 0, 0, '0, 0);
      clk_edge();
      chk("single_valid", cop_valid, 1'b1);
      chk("single_rs1", cop_rs1, 32'h1234_5678);
      drive(0, '0, '0, '0, 1, 0, 1, 32'hDEAD_BEEF, 0);
      clk_edge();
      chk("single_wb_req", wb_req, 1'b1);
      chk("single_wb_addr", wb_addr, 5'd5);
      chk("single_wb_data", wb_data, 32'hDEAD_BEEF);
      idle(1);
      clk_edge();
      chk("single_busy", cop_busy, 1'b0);

      // back-pressure: rd 1..4 with wb_gnt low
      wb_seen = 0;
      drive(1, C0, 32'h11, 5'd1, 0, 0, 0, '0, 0);
      clk_edge();
      drive(1, C1, 32'h22, 5'd2, cop_rdywr, 0, 1,
            32'hD000_0001, 0);
      clk_edge();
      drive(1, C3, 32'h33, 5'd3, cop_rdywr, 0, 1,
            32'hD000_0002, 0);
      clk_edge();
      for (int i = 0; i < 3; i++) begin
         drive(1, C2, 32'h44, 5'd4, cop_rdywr, 0, 1,
               32'hD000_0003, 0);
         chk("bp_ex_ready", ex_ready, 1'b0);
         chk("bp_rdywr", cop_rdywr, 1'b0);
         clk_edge();
         chk("bp_valid", cop_valid, 1'b1);
         chk("bp_insn", cop_insn, C3);
      end
      drive(1, C2, 32'h44, 5'd4, cop_rdywr, 0, 1,
            32'hD000_0003, 1);
      clk_edge();
      drive(1, C2, 32'h44, 5'd4, cop_rdywr, 0, 1,
            32'hD000_0003, 1);
      clk_edge();
      drive(0, '0, '0, '0, cop_rdywr, 0, 1,
            32'hD000_0004, 1);
      clk_edge();
      for (int i = 0; i < 3; i++) begin
         idle(1);
         clk_edge();
      end
      chk("bp_wb_count", wb_seen, 4);

      // rd = x0 result is discarded
      drive(1, C1, 32'h55, 5'd0, 0, 0, 0, '0, 0);
      clk_edge();
      drive(0, '0, '0, '0, 1, 0, 1, 32'hBAD0_0000, 0);
      clk_edge();
      chk("x0_wb_req", wb_req, 1'b0);
      chk("x0_valid", cop_valid, 1'b0);
      chk("x0_illegal", ex_illegal, 1'b0);

      // rejected insn, then a non-custom opcode
      drive(1, C0, 32'h66, 5'd7, 0, 0, 0, '0, 0);
      clk_edge();
      drive(0, '0, '0, '0, 1, 0, 0, '0, 0);
      clk_edge();
      chk("ill_pulse", ex_illegal, 1'b1);
      chk("ill_wb_req", wb_req, 1'b0);
      idle(0);
      clk_edge();
      chk("ill_clear", ex_illegal, 1'b0);
      drive(1, ALU, 32'h77, 5'd8, 0, 0, 0, '0, 0);
      clk_edge();
      chk("alu_ignored", cop_valid, 1'b0);

      // watchdog with WAIT_MAX = 4
      drive(1, C3, 32'h88, 5'd9, 0, 0, 0, '0, 0);
      clk_edge();
      for (int i = 0; i < 4; i++) begin
         drive(0, '0, '0, '0, 0, 1, 0, '0, 0);
         chk("wd_ex_ready", ex_ready, 1'b0);
         clk_edge();
      end
      chk("wd_fault", ex_fault, 1'b1);
      chk("wd_valid", cop_valid, 1'b0);
      drive(1, C2, 32'h99, 5'd10, 0, 0, 0, '0, 0);
      clk_edge();
      chk("wd_fault_clear", ex_fault, 1'b0);
      chk("wd_reaccept", cop_valid, 1'b1);
      drive(0, '0, '0, '0, 1, 0, 1, 32'hCAFE_0010, 0);
      clk_edge();
      idle(1);
      clk_edge();

      // reset in ISSUE with one FIFO entry
      drive(1, C0, 32'hAA, 5'd11, 0, 0, 0, '0, 0);
      clk_edge();
      drive(1, C1, 32'hBB, 5'd12, 1, 0, 1,
            32'h5555_AAAA, 0);
      clk_edge();
      chk("mid_wb_req", wb_req, 1'b1);
      chk("mid_valid", cop_valid, 1'b1);
      cop_rst = 1'b1;
      idle(0);
      clk_edge();
      reset_vals();
      cop_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         clk_edge();
      end
      chk("mid_no_stale", wb_req, 1'b0);
      chk("sb_empty", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cop_req_ctrl.md
# cop_req_ctrl

Core-side controller directly upstream of the coprocessor ISE port. It accepts custom-opcode instructions from the execute stage and drives the coprocessor request bus. It captures completed results into a 2-entry response FIFO and arbitrates them onto the register-file write port. It also generates the `cop_rdywr` back-pressure, reports unsupported instructions, and aborts requests that wait too long.

## Interface
- `WAIT_MAX`, 255: maximum consecutive `cop_wait` cycles before abort (1..255; 8-bit counter).

- `cop_clk` in 1: clock; all state updates on its rising edge.
- `cop_rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: execute stage presents an instruction.
- `ex_insn` in 32: instruction word.
- `ex_rs1`, `ex_rs2` in 32 each: operand values.
- `ex_rd_addr` in 5: destination register.
- `ex_ready` out 1: request accepted this cycle when `ex_valid` is high.
- `ex_illegal` out 1: one-cycle pulse; the coprocessor rejected the instruction.
- `ex_fault` out 1: one-cycle pulse; the request was aborted by the `WAIT_MAX` watchdog.
- `cop_busy` out 1: a request is in flight or the FIFO is non-empty.
- `cop_valid` out 1: request valid.
- `cop_insn`, `cop_rs1`, `cop_rs2` out 32 each: registered request fields.
- `cop_rdywr` out 1: controller can absorb a result.
- `cop_ready` in 1: coprocessor completion/stall signal.
- `cop_wait` in 1: coprocessor needs more cycles.
- `cop_wr` in 1: result is valid and must be written.
- `cop_rd` in 32: result data.
- `wb_req` out 1: FIFO head is valid.
- `wb_addr` out 5: FIFO head destination register.
- `wb_data` out 32: FIFO head data.
- `wb_gnt` in 1: register-file port granted this cycle.

## Operation
- Custom opcode: `ex_insn[6:0]` ∈ {0001011, 0101011, 1011011, 1111011}.
  - `ex_valid` with any other opcode is ignored: no state change, no pulse.
- FSM has two states, IDLE and ISSUE. Reset state is IDLE.
- `done` = ISSUE & `cop_ready` & ~`cop_wait`.
- `ex_ready` = IDLE | `done`.
- Accept = `ex_valid` & custom & `ex_ready`.
  - On accept, latch `ex_insn`, `ex_rs1`, `ex_rs2` into the `cop_*` registers, latch `ex_rd_addr` internally, clear the wait counter, and go to ISSUE.
  - Accept on the `done` cycle gives back-to-back issue: the state stays ISSUE with the new fields.
- `cop_valid` = (state == ISSUE).
  - Request fields are held stable while in ISSUE.
- In ISSUE, each of the following is evaluated in priority order, first match wins:
  - `done` & `cop_wr` & rd≠0: push {rd, `cop_rd`} into the FIFO.
  - `done` & `cop_wr` & rd=0: result discarded; treated as a normal completion.
  - `done` & ~`cop_wr`: pulse `ex_illegal` next cycle; nothing is pushed.
  - `cop_wait`: wait counter increments. When it reaches `WAIT_MAX`, pulse `ex_fault` next cycle, return to IDLE, and push nothing. `ex_ready` is 0 on the abort cycle.
  - ~`cop_ready` & ~`cop_wait` (write stalled): hold; the wait counter does not advance.
- `done` without a new accept returns the FSM to IDLE.
- `cop_rdywr` = FIFO count < 2.
  - Combinational from the registered count; there is no same-cycle pop bypass.
- FIFO is 2 entries of 37 bits with pointer wrap.
  - `wb_req` = count ≠ 0; head is presented on `wb_addr`/`wb_data`.
  - Pop when `wb_req` & `wb_gnt`.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push when full cannot occur because `cop_rdywr` = 0 prevents it. A push when full must be flagged by an assertion.
- `cop_busy` = (state == ISSUE) | `wb_req`.
- Reset, including mid-operation:
  - FIFO flushed.
  - Outputs: `cop_valid`=0, `cop_insn`/`cop_rs1`/`cop_rs2`=0, `wb_req`=0, `wb_addr`=0, `wb_data`=0, `ex_illegal`=0, `ex_fault`=0, `cop_busy`=0, `ex_ready`=1, `cop_rdywr`=1.

## Timing
- Accept at edge N → `cop_valid`=1 in cycle N+1.
- Zero-wait completion in N+1 → `wb_req`=1 in N+2.
- Throughput: one instruction per cycle while the FIFO drains (`wb_gnt`=1).
- `wb_gnt`=0 with the FIFO full:
  - `cop_rdywr`=0 and the coprocessor drops `cop_ready`.
  - `cop_valid` stays asserted and `ex_ready`=0.
  - Resumes in the cycle after the first pop.
- `ex_illegal`/`ex_fault` are registered, asserted exactly one cycle after the triggering edge.
- Watchdog: with `cop_wait` held, the request issued at N+1 aborts after `WAIT_MAX` wait cycles. `cop_valid` falls on the following cycle.

## Test plan
- Single op: custom-2 insn, rs1=0x1234_5678, rd=5; coprocessor returns `cop_wr`=1, `cop_rd`=0xDEAD_BEEF → `wb_req` in N+2 with `wb_addr`=5, `wb_data`=0xDEAD_BEEF; `cop_busy` falls after `wb_gnt`.
- Back-pressure: 4 back-to-back ops to rd=1..4 with `wb_gnt`=0 → FIFO holds rd 1,2; `cop_rdywr`=0; third op held with `cop_valid`=1 and `ex_ready`=0. With `wb_gnt`=1, writebacks occur in order 1,2,3,4 with no loss or duplicate.
- rd=x0 op with `cop_wr`=1 → no `wb_req`, FSM returns to IDLE, `ex_illegal`=0.
- Unsupported insn (coprocessor `cop_wr`=0, `cop_ready`=1) → one-cycle `ex_illegal`, FIFO count 0; non-custom opcode 0110011 with `ex_valid` → ignored, `cop_valid` stays 0.
- `WAIT_MAX`=4 with `cop_wait` held high → `ex_fault` pulse after 4 wait cycles, `cop_valid` drops, next custom insn accepted normally.
- `cop_rst` asserted while in ISSUE with FIFO count 1 → next cycle all outputs at their reset values, `wb_req`=0, and no stale writeback after release.
